// File: rtl/conv_pkg.sv
// Shared constants for the 5x5 conv sequencer: FSM state encoding, kernel geometry and
// config header word offsets.
package conv_pkg;
  localparam int KNL_DIM    = 5;
  localparam int KNL_SIZE   = 25;
  localparam int KNL_MAXNUM = 16;

  localparam logic [1:0] CFG_NUM_KNLS = 2'd0;
  localparam logic [1:0] CFG_IFMAP_W  = 2'd1;
  localparam logic [1:0] CFG_IFMAP_H  = 2'd2;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CFG_RD    = 4'd1;
  localparam logic [3:0] S_CFG_WAIT  = 4'd2;
  localparam logic [3:0] S_KNL_RD    = 4'd3;
  localparam logic [3:0] S_KNL_WAIT  = 4'd4;
  localparam logic [3:0] S_WIN_RD    = 4'd5;
  localparam logic [3:0] S_WIN_WAIT  = 4'd6;
  localparam logic [3:0] S_PSUM_RD   = 4'd7;
  localparam logic [3:0] S_PSUM_WAIT = 4'd8;
  localparam logic [3:0] S_WR        = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;
endpackage

// File: rtl/conv_addr_gen.sv
// Combinational DRAM address generation for config, kernel, ifmap window and ofmap accesses.
// All arithmetic is unsigned and wraps at ADDR_WIDTH bits.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] CFG_BASE   = 18'h0,
  parameter logic [ADDR_WIDTH-1:0] KNL_BASE   = 18'h10,
  parameter logic [ADDR_WIDTH-1:0] IFMAP_BASE = 18'h400,
  parameter logic [ADDR_WIDTH-1:0] OFMAP_BASE = 18'h8000
) (
  input  logic [1:0]            cfg_idx,
  input  logic [8:0]            knl_idx,
  input  logic [7:0]            x,
  input  logic [7:0]            y,
  input  logic [7:0]            w,
  input  logic [7:0]            h,
  input  logic [2:0]            row,
  input  logic [2:0]            col,
  input  logic [4:0]            ch,
  output logic [ADDR_WIDTH-1:0] cfg_addr,
  output logic [ADDR_WIDTH-1:0] knl_addr,
  output logic [ADDR_WIDTH-1:0] win_addr,
  output logic [ADDR_WIDTH-1:0] ofm_addr
);
  logic [ADDR_WIDTH-1:0] w_a, ow_a, oh_a;

  // Output plane is the valid-convolution size: W-4 by H-4.
  assign w_a  = ADDR_WIDTH'(w);
  assign ow_a = ADDR_WIDTH'(w - 8'(KNL_DIM - 1));
  assign oh_a = ADDR_WIDTH'(h - 8'(KNL_DIM - 1));

  assign cfg_addr = CFG_BASE + ADDR_WIDTH'(cfg_idx);
  assign knl_addr = KNL_BASE + ADDR_WIDTH'(knl_idx);
  assign win_addr = IFMAP_BASE + (ADDR_WIDTH'(y) + ADDR_WIDTH'(row)) * w_a
                  + ADDR_WIDTH'(x) + ADDR_WIDTH'(col);
  assign ofm_addr = OFMAP_BASE + ADDR_WIDTH'(ch) * oh_a * ow_a
                  + ADDR_WIDTH'(y) * ow_a + ADDR_WIDTH'(x);
endmodule

// File: rtl/conv_sched.sv
// Layer sequencer for the 5x5 conv datapath: config fetch, kernel/window streaming, ofmap writes.
// Define CONV_ACC_EN to read back each ofmap word as a partial sum before writing it.
module conv_sched
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] CFG_BASE   = 18'h0,
  parameter logic [ADDR_WIDTH-1:0] KNL_BASE   = 18'h10,
  parameter logic [ADDR_WIDTH-1:0] IFMAP_BASE = 18'h400,
  parameter logic [ADDR_WIDTH-1:0] OFMAP_BASE = 18'h8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  en_ld_knl,
  output logic                  en_ld_ifmap,
  output logic                  disable_acc,
  output logic [5:0]            num_knls,
  output logic [4:0]            cnt_ofmap_chnl_ff,
  output logic                  done
);
  function automatic logic [5:0] sat_knls(input logic [DATA_WIDTH-1:0] raw);
    if (raw > DATA_WIDTH'(KNL_MAXNUM)) return 6'(KNL_MAXNUM);
    return raw[5:0];
  endfunction

`ifdef CONV_ACC_EN
  localparam logic [3:0] S_WRITE = S_PSUM_RD;
`else
  localparam logic [3:0] S_WRITE = S_WR;
`endif

  logic [3:0] state;
  logic [1:0] cfg_idx;
  logic [8:0] knl_idx;
  logic [2:0] row, col;
  logic [7:0] x, y, w_r, h_r;
  logic [5:0] num_knls_r;
  logic [4:0] ch;
  logic       disable_acc_r;
  logic [ADDR_WIDTH-1:0] cfg_addr, knl_addr, win_addr, ofm_addr;
  logic [8:0] knl_total;
  logic knl_last, win_last, ch_last, px_last, cfg_bad, wr_fire;

  conv_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .CFG_BASE(CFG_BASE), .KNL_BASE(KNL_BASE),
    .IFMAP_BASE(IFMAP_BASE), .OFMAP_BASE(OFMAP_BASE)
  ) u_addr_gen (
    .cfg_idx(cfg_idx), .knl_idx(knl_idx), .x(x), .y(y), .w(w_r), .h(h_r),
    .row(row), .col(col), .ch(ch),
    .cfg_addr(cfg_addr), .knl_addr(knl_addr), .win_addr(win_addr), .ofm_addr(ofm_addr)
  );

  assign knl_total = 9'(num_knls_r) * 9'(KNL_SIZE);
  assign knl_last  = (knl_idx == knl_total - 9'd1);
  assign win_last  = (row == 3'(KNL_DIM - 1)) && (col == 3'(KNL_DIM - 1));
  assign ch_last   = (ch == 5'(num_knls_r - 6'd1));
  assign px_last   = (x == w_r - 8'(KNL_DIM)) && (y == h_r - 8'(KNL_DIM));
  // H is still on data_in when the last config word lands, so check it there.
  assign cfg_bad   = (num_knls_r == 6'd0) || (w_r < 8'(KNL_DIM)) ||
                     (data_in[7:0] < 8'(KNL_DIM));

`ifdef CONV_ACC_EN
  assign wr_fire = (state == S_PSUM_WAIT) && dram_valid;
`else
  assign wr_fire = (state == S_WR);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_idx    <= '0;
      knl_idx    <= '0;
      row        <= '0;
      col        <= '0;
      x          <= '0;
      y          <= '0;
      w_r        <= '0;
      h_r        <= '0;
      num_knls_r <= '0;
      ch         <= '0;
    end else begin
      case (state)
        S_IDLE: if (enable) begin
          state   <= S_CFG_RD;
          cfg_idx <= '0;
          knl_idx <= '0;
          row     <= '0;
          col     <= '0;
          x       <= '0;
          y       <= '0;
          ch      <= '0;
        end
        S_CFG_RD: state <= S_CFG_WAIT;
        S_CFG_WAIT: if (dram_valid) begin
          case (cfg_idx)
            CFG_NUM_KNLS: num_knls_r <= sat_knls(data_in);
            CFG_IFMAP_W:  w_r <= data_in[7:0];
            default:      h_r <= data_in[7:0];
          endcase
          cfg_idx <= cfg_idx + 2'd1;
          if (cfg_idx == CFG_IFMAP_H) state <= cfg_bad ? S_DONE : S_KNL_RD;
          else state <= S_CFG_RD;
        end
        S_KNL_RD: state <= S_KNL_WAIT;
        S_KNL_WAIT: if (dram_valid) begin
          knl_idx <= knl_idx + 9'd1;
          state   <= knl_last ? S_WIN_RD : S_KNL_RD;
        end
        S_WIN_RD: state <= S_WIN_WAIT;
        // Window is column-major: row advances fastest.
        S_WIN_WAIT: if (dram_valid) begin
          if (win_last) begin
            row   <= '0;
            col   <= '0;
            state <= S_WRITE;
          end else begin
            if (row == 3'(KNL_DIM - 1)) begin
              row <= '0;
              col <= col + 3'd1;
            end else begin
              row <= row + 3'd1;
            end
            state <= S_WIN_RD;
          end
        end
        S_PSUM_RD: state <= S_PSUM_WAIT;
        S_PSUM_WAIT, S_WR: if (wr_fire) begin
          if (ch_last) begin
            ch <= '0;
            if (px_last) begin
              state <= S_DONE;
            end else begin
              if (x == w_r - 8'(KNL_DIM)) begin
                x <= '0;
                y <= y + 8'd1;
              end else begin
                x <= x + 8'd1;
              end
              state <= S_WIN_RD;
            end
          end else begin
            ch    <= ch + 5'd1;
            state <= S_WRITE;
          end
        end
        S_DONE: if (!enable) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) disable_acc_r <= 1'b0;
`ifdef CONV_ACC_EN
    else     disable_acc_r <= 1'b0;
`else
    else     disable_acc_r <= 1'b1;
`endif
  end

  always_comb begin
    addr_in = '0;
    case (state)
      S_CFG_RD, S_CFG_WAIT:   addr_in = cfg_addr;
      S_KNL_RD, S_KNL_WAIT:   addr_in = knl_addr;
      S_WIN_RD, S_WIN_WAIT:   addr_in = win_addr;
      S_PSUM_RD, S_PSUM_WAIT: addr_in = ofm_addr;
      default:                addr_in = '0;
    endcase
  end

  assign addr_out = (state == S_WR || state == S_PSUM_RD || state == S_PSUM_WAIT) ? ofm_addr : '0;
  assign dram_en_rd = (state == S_CFG_RD) || (state == S_KNL_RD) ||
                      (state == S_WIN_RD) || (state == S_PSUM_RD);
  assign dram_en_wr        = wr_fire;
  assign en_ld_knl         = (state == S_KNL_WAIT) && dram_valid;
  assign en_ld_ifmap       = (state == S_WIN_WAIT) && dram_valid;
  assign disable_acc       = disable_acc_r;
  assign num_knls          = num_knls_r;
  assign cnt_ofmap_chnl_ff = ch;
  assign done              = (state == S_DONE);
endmodule
